// File: rtl/amp_init_seq.sv
// amp_init_seq: external amplifier power-up / shutdown sequencer.
// Enables the amp, streams a {reg,data} table over I2C, then unmutes.
module amp_init_seq #(
  parameter logic [15:0] WAIT_PWRUP  = 16'd12000,
  parameter logic [15:0] WAIT_UNMUTE = 16'd1200,
  parameter int unsigned MAX_RETRY   = 2,
  parameter logic [6:0]  DEV_ADDR    = 7'h2C
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        ena,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  tbl_len,
  output logic [3:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic        m_req,
  output logic [6:0]  m_dev,
  output logic [7:0]  m_reg,
  output logic [7:0]  m_data,
  input  logic        m_ack,
  input  logic        m_nack,
  output logic        amp_nenable,
  output logic        amp_nmute,
  output logic        busy,
  output logic        ready,
  output logic        err,
  output logic [3:0]  err_idx
);

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_LATCH, S_ISSUE,
    S_UNMUTE, S_RUN, S_MUTE, S_ERROR
  } state_t;

  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_t      state;
  logic [15:0] timer;
  logic [3:0]  retry;
  logic [3:0]  idx;
  logic [3:0]  len;
  logic        stop_pend;
  logic        stop_req;
  logic        go;
  logic        pwr_done;
  logic        unm_done;
  logic        halt;

  assign stop_req = stop | ~ena;
  assign go       = start & ena & ~stop;
  assign halt     = stop_req | stop_pend;
  assign m_dev    = DEV_ADDR;

  // A zero wait still spends one cycle in the state.
  assign pwr_done = ({1'b0, timer} + 17'd1) >= {1'b0, WAIT_PWRUP};
  assign unm_done = ({1'b0, timer} + 17'd1) >= {1'b0, WAIT_UNMUTE};

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= S_IDLE;
      timer       <= '0;
      retry       <= '0;
      idx         <= '0;
      len         <= '0;
      stop_pend   <= 1'b0;
      tbl_addr    <= '0;
      m_req       <= 1'b0;
      m_reg       <= '0;
      m_data      <= '0;
      amp_nenable <= 1'b1;
      amp_nmute   <= 1'b0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      err         <= 1'b0;
      err_idx     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_ERROR: begin
          if (go) begin
            state       <= S_PWRUP;
            amp_nenable <= 1'b0;
            amp_nmute   <= 1'b0;
            timer       <= '0;
            retry       <= '0;
            idx         <= '0;
            len         <= tbl_len;
            stop_pend   <= 1'b0;
            err         <= 1'b0;
            err_idx     <= '0;
            busy        <= 1'b1;
          end
        end
        S_PWRUP: begin
          if (stop_req) begin
            state <= S_MUTE;
            timer <= '0;
          end else if (pwr_done) begin
            timer <= '0;
            state <= (len != 4'd0) ? S_FETCH : S_UNMUTE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_FETCH: begin
          if (stop_req) begin
            state <= S_MUTE;
            timer <= '0;
          end else begin
            tbl_addr <= idx;
            state    <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (stop_req) begin
            state <= S_MUTE;
            timer <= '0;
          end else begin
            m_reg  <= tbl_data[15:8];
            m_data <= tbl_data[7:0];
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!m_req) begin
            if (halt) begin
              state     <= S_MUTE;
              timer     <= '0;
              stop_pend <= 1'b0;
            end else begin
              m_req <= 1'b1;
            end
          end else if (m_ack) begin
            m_req     <= 1'b0;
            retry     <= '0;
            idx       <= idx + 4'd1;
            timer     <= '0;
            stop_pend <= 1'b0;
            if (halt)
              state <= S_MUTE;
            else if (idx + 4'd1 == len)
              state <= S_UNMUTE;
            else
              state <= S_FETCH;
          end else if (m_nack) begin
            m_req     <= 1'b0;
            timer     <= '0;
            stop_pend <= 1'b0;
            if (halt) begin
              state <= S_MUTE;
            end else if (retry < RETRY_MAX) begin
              retry <= retry + 4'd1;
            end else begin
              state       <= S_ERROR;
              err         <= 1'b1;
              err_idx     <= idx;
              busy        <= 1'b0;
              amp_nenable <= 1'b1;
              amp_nmute   <= 1'b0;
            end
          end else begin
            // Stop during a live write is honoured once it completes.
            stop_pend <= halt;
          end
        end
        S_UNMUTE: begin
          if (stop_req) begin
            state <= S_MUTE;
            timer <= '0;
          end else if (unm_done) begin
            state     <= S_RUN;
            amp_nmute <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_RUN: begin
          if (stop_req) begin
            state     <= S_MUTE;
            amp_nmute <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            timer     <= '0;
          end
        end
        S_MUTE: begin
          if (unm_done) begin
            state       <= S_IDLE;
            amp_nenable <= 1'b1;
            busy        <= 1'b0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
